// File: rtl/ctrl_clock_cpu.sv
// CPU clock/step/reset controller: debounced keys, divider, HOLD/STEP/AUTO/BURST sequencing.
// Optional CLK_CTRL_HALT_EN adds a parada input that halts AUTO/BURST pulsing.
module ctrl_clock_cpu #(
  parameter int unsigned DIV_W    = 26,
  parameter int unsigned DEB_W    = 20,
  parameter int unsigned DEB_MAX  = 280000,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned RST_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] divisor,
  input  logic [1:0]       modo,
  input  logic             chave_step,
  input  logic             chave_rst,
  input  logic [CNT_W-1:0] rajada,
`ifdef CLK_CTRL_HALT_EN
  input  logic             parada,
`endif
  output logic             cpu_en,
  output logic             cpu_rst,
  output logic [CNT_W-1:0] ciclos,
  output logic             ocupado,
  output logic             led_tick
);

  localparam int unsigned HW = $clog2(RST_HOLD + 1);
  localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_MAX - 1);
  localparam logic [HW-1:0]    HOLD_LAST = HW'(RST_HOLD - 1);

  typedef enum logic [1:0] {StHold, StStep, StAuto, StBurst} state_e;

  // Bit 0 is the step key, bit 1 the reset key.
  logic [1:0]       key_s1_q, key_s2_q, lvl_q, lvl_prev_q;
  logic [DEB_W-1:0] deb_cnt_q [2];

  always_ff @(posedge clk) begin
    if (!rst) begin
      key_s1_q   <= '1;
      key_s2_q   <= '1;
      lvl_q      <= '1;
      lvl_prev_q <= '1;
      for (int i = 0; i < 2; i++) deb_cnt_q[i] <= '0;
    end else begin
      key_s1_q   <= {chave_rst, chave_step};
      key_s2_q   <= key_s1_q;
      lvl_prev_q <= lvl_q;
      for (int i = 0; i < 2; i++) begin
        if (key_s2_q[i] == lvl_q[i]) begin
          deb_cnt_q[i] <= '0;
        end else if (deb_cnt_q[i] == DEB_LAST) begin
          lvl_q[i]     <= key_s2_q[i];
          deb_cnt_q[i] <= '0;
        end else begin
          deb_cnt_q[i] <= deb_cnt_q[i] + DEB_W'(1);
        end
      end
    end
  end

  logic press_step, press_rst;
  assign press_step = lvl_prev_q[0] & ~lvl_q[0];
  assign press_rst  = lvl_prev_q[1] & ~lvl_q[1];

  state_e           state_q, tgt;
  logic [HW-1:0]    hold_cnt_q;
  logic [DIV_W-1:0] div_cnt_q;
  logic [CNT_W-1:0] resto_q;
  logic             halt_q, halt_set, tick, pulse;

  always_comb begin
    unique case (modo)
      2'b01:   tgt = StAuto;
      2'b10:   tgt = StBurst;
      default: tgt = StStep;
    endcase
  end

  // >= so that lowering the divisor mid-count fires at once.
  assign tick = (div_cnt_q >= divisor);

`ifdef CLK_CTRL_HALT_EN
  assign halt_set = parada & ((state_q == StAuto) | ((state_q == StBurst) & ocupado));
`else
  assign halt_set = 1'b0;
`endif

  always_comb begin
    pulse = 1'b0;
    if (state_q != StHold && !press_rst && tgt == state_q) begin
      case (state_q)
        StStep:  pulse = press_step;
        StAuto:  pulse = halt_q ? press_step : tick;
        StBurst: pulse = ocupado & (halt_q ? press_step : tick);
        default: pulse = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StHold;
      hold_cnt_q <= '0;
      div_cnt_q  <= '0;
      resto_q    <= '0;
      halt_q     <= 1'b0;
      cpu_en     <= 1'b0;
      cpu_rst    <= 1'b1;
      ciclos     <= '0;
      ocupado    <= 1'b0;
      led_tick   <= 1'b0;
    end else begin
      cpu_en <= pulse;
      if (pulse) begin
        if (ciclos != '1) ciclos <= ciclos + CNT_W'(1);
        led_tick <= ~led_tick;
      end
      if (state_q == StHold) begin
        cpu_rst   <= 1'b1;
        ciclos    <= '0;
        ocupado   <= 1'b0;
        div_cnt_q <= '0;
        halt_q    <= 1'b0;
        if (press_rst) begin
          hold_cnt_q <= '0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          hold_cnt_q <= '0;
          state_q    <= tgt;
          cpu_rst    <= 1'b0;
        end else begin
          hold_cnt_q <= hold_cnt_q + HW'(1);
        end
      end else if (press_rst) begin
        state_q    <= StHold;
        cpu_rst    <= 1'b1;
        ciclos     <= '0;
        ocupado    <= 1'b0;
        div_cnt_q  <= '0;
        hold_cnt_q <= '0;
        halt_q     <= 1'b0;
      end else if (tgt != state_q) begin
        state_q   <= tgt;
        ocupado   <= 1'b0;
        div_cnt_q <= '0;
        halt_q    <= 1'b0;
      end else begin
        if (halt_set) halt_q <= 1'b1;
        case (state_q)
          StAuto: begin
            if (!halt_q) div_cnt_q <= tick ? '0 : div_cnt_q + DIV_W'(1);
          end
          StBurst: begin
            if (ocupado) begin
              if (!halt_q) begin
                div_cnt_q <= tick ? '0 : div_cnt_q + DIV_W'(1);
                if (tick) begin
                  resto_q <= resto_q - CNT_W'(1);
                  if (resto_q == CNT_W'(1)) ocupado <= 1'b0;
                end
              end
            end else if (press_step && rajada != '0) begin
              resto_q   <= rajada;
              ocupado   <= 1'b1;
              div_cnt_q <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
